// File: rtl/mem_access_unit.sv
// Memory access unit: control-FSM requests to an Avalon-MM master port.
// Optional macro MEM_ALIGN_CHECK_EN traps misaligned word accesses.
module mem_access_unit #(
   parameter int WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [1:0]  req_kind,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        done,
   output logic [31:0] instr,
   output logic [31:0] mdr,
   output logic        bus_error,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest
);

   localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

   localparam logic [1:0] K_FETCH = 2'b00;
   localparam logic [1:0] K_LW    = 2'b01;
   localparam logic [1:0] K_LB    = 2'b10;
   localparam logic [1:0] K_SW    = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      ERROR
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [1:0]    kind_q, kind_d;
   logic [1:0]    off_q, off_d;
   logic          read_q, read_d;
   logic          write_q, write_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   mdr_q, mdr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic [7:0]    lb_byte;
   logic [31:0]   lb_ext;
   logic          misaligned;

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = (req_kind != K_LB) && (req_addr[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   assign cnt_inc = cnt_q + CW'(1);

   // Select the addressed byte (little-endian) and sign-extend it
   always_comb begin
      lb_byte = avm_readdata[7:0];
      unique case (off_q)
         2'd0: lb_byte = avm_readdata[7:0];
         2'd1: lb_byte = avm_readdata[15:8];
         2'd2: lb_byte = avm_readdata[23:16];
         2'd3: lb_byte = avm_readdata[31:24];
      endcase
      lb_ext = {{24{lb_byte[7]}}, lb_byte};
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      kind_d  = kind_q;
      off_d   = off_q;
      read_d  = read_q;
      write_d = write_q;
      done_d  = 1'b0;
      err_d   = err_q;
      instr_d = instr_q;
      mdr_d   = mdr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (misaligned) begin
                  state_d = ERROR;
                  err_d   = 1'b1;
               end else begin
                  addr_d  = {req_addr[31:2], 2'b00};
                  off_d   = req_addr[1:0];
                  kind_d  = req_kind;
                  wdata_d = req_wdata;
                  cnt_d   = '0;
                  if (req_kind == K_SW) begin
                     state_d = WRITE;
                     write_d = 1'b1;
                  end else begin
                     state_d = READ;
                     read_d  = 1'b1;
                  end
               end
            end
         end
         READ, WRITE: begin
            if (!avm_waitrequest) begin
               read_d  = 1'b0;
               write_d = 1'b0;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
               if (state_q == READ) begin
                  case (kind_q)
                     K_FETCH: instr_d = avm_readdata;
                     K_LW:    mdr_d   = avm_readdata;
                     K_LB:    mdr_d   = lb_ext;
                     default: ;
                  endcase
               end
            end else if (WAIT_LIMIT > 0) begin
               if (cnt_inc == LIMIT) begin
                  read_d  = 1'b0;
                  write_d = 1'b0;
                  err_d   = 1'b1;
                  state_d = ERROR;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         ERROR: begin
            read_d  = 1'b0;
            write_d = 1'b0;
            err_d   = 1'b1;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         kind_q  <= '0;
         off_q   <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         instr_q <= '0;
         mdr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         kind_q  <= kind_d;
         off_q   <= off_d;
         read_q  <= read_d;
         write_q <= write_d;
         done_q  <= done_d;
         err_q   <= err_d;
         instr_q <= instr_d;
         mdr_q   <= mdr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign req_ready      = (state_q == IDLE);
   assign done           = done_q;
   assign instr          = instr_q;
   assign mdr            = mdr_q;
   assign bus_error      = err_q;
   assign avm_address    = addr_q;
   assign avm_read       = read_q;
   assign avm_write      = write_q;
   assign avm_writedata  = wdata_q;
   assign avm_byteenable = 4'b1111;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (WAIT_LIMIT = 4).
// Honours MEM_ALIGN_CHECK_EN in the alignment scenario.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [1:0]  req_kind;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        done;
   logic [31:0] instr;
   logic [31:0] mdr;
   logic        bus_error;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;

   int checks = 0;
   int errors = 0;

   mem_access_unit #(.WAIT_LIMIT(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_kind        (req_kind),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_ready       (req_ready),
      .done            (done),
      .instr           (instr),
      .mdr             (mdr),
      .bus_error       (bus_error),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] k, input logic [31:0] a,
                        input logic [31:0] d);
      req_valid = 1'b1;
      req_kind  = k;
      req_addr  = a;
      req_wdata = d;
      step();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL rst_ready got %b want 1", req_ready);
      end
      checks++;
      if (done !== 1'b0 || bus_error !== 1'b0) begin
         errors++; $display("FAIL rst_flags got done=%b err=%b want 0 0", done, bus_error);
      end
      checks++;
      if (instr !== 32'h0 || mdr !== 32'h0) begin
         errors++; $display("FAIL rst_regs got %h %h want 0 0", instr, mdr);
      end
      checks++;
      if (avm_read !== 1'b0 || avm_write !== 1'b0 || avm_address !== 32'h0
          || avm_writedata !== 32'h0) begin
         errors++; $display("FAIL rst_bus got r=%b w=%b a=%h d=%h want 0", avm_read,
                            avm_write, avm_address, avm_writedata);
      end
   endtask

   task automatic test_fetch();
      avm_waitrequest = 1'b0;
      avm_readdata    = 32'h24020005;
      issue(2'b00, 32'hBFC00000, 32'h0);
      checks++;
      if (avm_read !== 1'b1 || avm_address !== 32'hBFC00000) begin
         errors++; $display("FAIL fetch_strobe got r=%b a=%h want 1 bfc00000", avm_read, avm_address);
      end
      checks++;
      if (req_ready !== 1'b0 || done !== 1'b0 || avm_byteenable !== 4'hF) begin
         errors++; $display("FAIL fetch_n1 got rdy=%b done=%b be=%h want 0 0 f", req_ready,
                            done, avm_byteenable);
      end
      step();
      checks++;
      if (done !== 1'b1 || instr !== 32'h24020005) begin
         errors++; $display("FAIL fetch_done got done=%b instr=%h want 1 24020005", done, instr);
      end
      checks++;
      if (avm_read !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL fetch_n2 got r=%b rdy=%b want 0 1", avm_read, req_ready);
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL fetch_pulse got %b want 0", done);
      end
   endtask

   task automatic test_load_byte();
      logic [31:0] addrs [4] = '{32'h1003, 32'h1001, 32'h1000, 32'h1002};
      logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h0, 32'h12, 32'hFFFFFFFF};
      avm_readdata = 32'h80FF0012;
      for (int i = 0; i < 4; i++) begin
         issue(2'b10, addrs[i], 32'h0);
         checks++;
         if (avm_address !== 32'h1000) begin
            errors++; $display("FAIL lb_addr%0d got %h want 00001000", i, avm_address);
         end
         step();
         checks++;
         if (done !== 1'b1 || mdr !== exps[i]) begin
            errors++; $display("FAIL lb_data%0d got done=%b mdr=%h want 1 %h", i, done, mdr, exps[i]);
         end
      end
      checks++;
      if (instr !== 32'h24020005) begin
         errors++; $display("FAIL lb_instr got %h want 24020005", instr);
      end
   endtask

   task automatic test_load_word();
      avm_readdata = 32'hCAFEF00D;
      issue(2'b01, 32'h3000, 32'h0);
      step();
      checks++;
      if (done !== 1'b1 || mdr !== 32'hCAFEF00D || instr !== 32'h24020005) begin
         errors++; $display("FAIL lw got done=%b mdr=%h instr=%h want 1 cafef00d 24020005",
                            done, mdr, instr);
      end
   endtask

   task automatic test_store();
      int wr = 0;
      int dn = 0;
      bit unstable = 1'b0;
      bit dbl = 1'b0;
      bit prev = 1'b0;
      avm_waitrequest = 1'b1;
      issue(2'b11, 32'h2000, 32'hDEADBEEF);
      for (int i = 0; i < 12; i++) begin
         if (avm_write === 1'b1) begin
            wr++;
            if (avm_address !== 32'h2000 || avm_writedata !== 32'hDEADBEEF)
               unstable = 1'b1;
         end
         if (avm_read !== 1'b0) unstable = 1'b1;
         if (done === 1'b1) begin
            dn++;
            if (prev) dbl = 1'b1;
         end
         prev = (done === 1'b1);
         avm_waitrequest = (avm_write === 1'b1) && (wr <= 3);
         step();
      end
      avm_waitrequest = 1'b0;
      checks++;
      if (wr != 4) begin
         errors++; $display("FAIL sw_cycles got %0d want 4", wr);
      end
      checks++;
      if (dn != 1 || dbl) begin
         errors++; $display("FAIL sw_done got %0d dbl=%b want 1 0", dn, dbl);
      end
      checks++;
      if (unstable) begin
         errors++; $display("FAIL sw_stable got 1 want 0");
      end
      checks++;
      if (mdr !== 32'hCAFEF00D || req_ready !== 1'b1) begin
         errors++; $display("FAIL sw_after got mdr=%h rdy=%b want cafef00d 1", mdr, req_ready);
      end
   endtask

   task automatic test_back_to_back();
      avm_readdata = 32'h11111111;
      issue(2'b01, 32'h4000, 32'h0);
      step();
      checks++;
      if (done !== 1'b1 || req_ready !== 1'b1 || mdr !== 32'h11111111) begin
         errors++; $display("FAIL b2b_first got done=%b rdy=%b mdr=%h want 1 1 11111111",
                            done, req_ready, mdr);
      end
      avm_readdata = 32'h22222222;
      issue(2'b00, 32'h4004, 32'h0);
      checks++;
      if (avm_read !== 1'b1 || avm_address !== 32'h4004 || done !== 1'b0) begin
         errors++; $display("FAIL b2b_second got r=%b a=%h done=%b want 1 4004 0",
                            avm_read, avm_address, done);
      end
      step();
      checks++;
      if (done !== 1'b1 || instr !== 32'h22222222 || mdr !== 32'h11111111) begin
         errors++; $display("FAIL b2b_done got done=%b instr=%h mdr=%h want 1 22222222 11111111",
                            done, instr, mdr);
      end
   endtask

   task automatic test_align();
`ifdef MEM_ALIGN_CHECK_EN
      issue(2'b01, 32'h1002, 32'h0);
      checks++;
      if (avm_read !== 1'b0 || bus_error !== 1'b1 || req_ready !== 1'b0) begin
         errors++; $display("FAIL align_trap got r=%b err=%b rdy=%b want 0 1 0",
                            avm_read, bus_error, req_ready);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (bus_error !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL align_rst got err=%b rdy=%b want 0 1", bus_error, req_ready);
      end
`else
      avm_readdata = 32'h5A5A5A5A;
      issue(2'b01, 32'h1002, 32'h0);
      checks++;
      if (avm_read !== 1'b1 || avm_address !== 32'h1000) begin
         errors++; $display("FAIL align_addr got r=%b a=%h want 1 00001000", avm_read, avm_address);
      end
      step();
      checks++;
      if (done !== 1'b1 || mdr !== 32'h5A5A5A5A || bus_error !== 1'b0) begin
         errors++; $display("FAIL align_done got done=%b mdr=%h err=%b want 1 5a5a5a5a 0",
                            done, mdr, bus_error);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int dn = 0;
      avm_waitrequest = 1'b0;
      avm_readdata    = 32'h13572468;
      issue(2'b00, 32'h5000, 32'h0);
      step();
      step();
      avm_waitrequest = 1'b1;
      avm_readdata    = 32'h99999999;
      issue(2'b00, 32'h6000, 32'h0);
      step();
      checks++;
      if (avm_read !== 1'b1 || instr !== 32'h13572468) begin
         errors++; $display("FAIL rmid_wait got r=%b instr=%h want 1 13572468", avm_read, instr);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      avm_waitrequest = 1'b0;
      checks++;
      if (avm_read !== 1'b0 || instr !== 32'h0 || done !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL rmid_rst got r=%b instr=%h done=%b rdy=%b want 0 0 0 1",
                            avm_read, instr, done, req_ready);
      end
      for (int i = 0; i < 3; i++) begin
         if (done === 1'b1) dn++;
         step();
      end
      checks++;
      if (dn != 0 || instr !== 32'h0) begin
         errors++; $display("FAIL rmid_after got done=%0d instr=%h want 0 0", dn, instr);
      end
   endtask

   task automatic test_watchdog();
      int rd = 0;
      int dn = 0;
      avm_waitrequest = 1'b1;
      issue(2'b01, 32'h7000, 32'h0);
      for (int i = 0; i < 10; i++) begin
         if (avm_read === 1'b1) rd++;
         if (done === 1'b1) dn++;
         step();
      end
      checks++;
      if (rd != 4 || dn != 0) begin
         errors++; $display("FAIL wd_cycles got rd=%0d done=%0d want 4 0", rd, dn);
      end
      checks++;
      if (bus_error !== 1'b1 || req_ready !== 1'b0 || avm_read !== 1'b0) begin
         errors++; $display("FAIL wd_err got err=%b rdy=%b r=%b want 1 0 0",
                            bus_error, req_ready, avm_read);
      end
      issue(2'b00, 32'h8000, 32'h0);
      checks++;
      if (avm_read !== 1'b0 || avm_write !== 1'b0 || bus_error !== 1'b1) begin
         errors++; $display("FAIL wd_terminal got r=%b w=%b err=%b want 0 0 1",
                            avm_read, avm_write, bus_error);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      avm_waitrequest = 1'b0;
      checks++;
      if (bus_error !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL wd_rst got err=%b rdy=%b want 0 1", bus_error, req_ready);
      end
   endtask

   initial begin
      reset           = 1'b1;
      req_valid       = 1'b0;
      req_kind        = 2'b00;
      req_addr        = 32'h0;
      req_wdata       = 32'h0;
      avm_readdata    = 32'h0;
      avm_waitrequest = 1'b0;
      #1;
      test_reset();
      test_fetch();
      test_load_byte();
      test_load_word();
      test_store();
      test_back_to_back();
      test_align();
      test_reset_mid();
      test_watchdog();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: WAIT_LIMIT, 255, max consecutive waitrequest-high cycles before bus error (0 = watchdog off).
REQ-002 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-003 Ports, in order:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  access request from control FSM
- req_kind  in  2  00 instr fetch, 01 load word, 10 load byte, 11 store word
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_ready  out  1  unit idle, request accepted this cycle if req_valid
- done  out  1  one-cycle pulse on access completion
- instr  out  32  instruction register
- mdr  out  32  memory data register
- bus_error  out  1  sticky fault flag
- avm_address  out  32  bus address
- avm_read  out  1  bus read strobe
- avm_write  out  1  bus write strobe
- avm_writedata  out  32  bus write data
- avm_byteenable  out  4  bus byte enables
- avm_readdata  in  32  bus read data, valid in the cycle waitrequest is low
- avm_waitrequest  in  1  bus stall

Function
REQ-004 SHALL implement FSM states IDLE, READ, WRITE, ERROR; req_ready=1 only in IDLE.
REQ-005 IDLE with req_valid=1: SHALL register address, kind, wdata; next state READ (kinds 00/01/10) or WRITE (kind 11).
REQ-006 avm_address SHALL be {req_addr[31:2],2'b00}; avm_byteenable SHALL be 4'b1111 for all accesses.
REQ-007 avm_read (READ) / avm_write (WRITE) SHALL be registered, asserted from the cycle after acceptance, held with address/data stable while avm_waitrequest=1.
REQ-008 READ with avm_waitrequest=0: SHALL capture avm_readdata into instr (kind 00) or mdr (kind 01); drop avm_read; pulse done next cycle; return IDLE.
REQ-009 Kind 10: mdr SHALL receive byte addr[1:0] of readdata (little-endian, byte 0 = bits 7:0), sign-extended to 32 bits.
REQ-010 WRITE with avm_waitrequest=0: SHALL drop avm_write, pulse done next cycle, return IDLE; instr/mdr unchanged.
REQ-011 Zero-wait latency: acceptance in cycle N -> strobe in N+1 -> done=1 and register updated in N+2, req_ready=1 in N+2.
REQ-012 req_valid SHALL be ignored when req_ready=0; instr/mdr SHALL change only at a completing read.
REQ-013 Watchdog (WAIT_LIMIT>0): counter SHALL count consecutive waitrequest-high cycles of the active strobe; reaching WAIT_LIMIT SHALL drop strobes, enter ERROR, set bus_error=1; no done pulse.
REQ-014 ERROR SHALL be terminal until reset: req_ready=0, strobes 0, bus_error held 1.
REQ-015 done SHALL never be high for two consecutive cycles.

Reset
REQ-016 Reset high at a clock edge SHALL force IDLE, instr=0, mdr=0, done=0, bus_error=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, watchdog counter=0; req_ready=1 afterwards.
REQ-017 Reset mid-access SHALL abandon the transfer without done pulse or register update; reset has priority over all other events.

Configuration
REQ-018 Macro MEM_ALIGN_CHECK_EN defined: word kinds (00/01/11) with req_addr[1:0]!=0 SHALL go from IDLE directly to ERROR with no bus strobe, bus_error=1 next cycle.
REQ-019 MEM_ALIGN_CHECK_EN undefined: req_addr[1:0] SHALL be ignored for word kinds and the access proceeds to the aligned word.

Verification
REQ-020 Fetch at 0xBFC00000, waitrequest=0, readdata=0x24020005 -> avm_read one cycle at 0xBFC00000, done in N+2, instr=0x24020005.
REQ-021 Load byte addr 0x1003, readdata=0x80FF0012 -> mdr=0xFFFFFF80; addr 0x1001 same data -> mdr=0x00000000.
REQ-022 Store word 0x2000 data 0xDEADBEEF, waitrequest high 3 cycles -> avm_write high 4 cycles with stable address/data, done once, mdr unchanged.
REQ-023 WAIT_LIMIT=4, waitrequest stuck high on load -> strobe dropped after 4 cycles, bus_error=1, req_ready=0, no done; reset -> bus_error=0, req_ready=1.
REQ-024 MEM_ALIGN_CHECK_EN defined, load word 0x1002 -> no avm_read, bus_error=1; undefined -> read at 0x1000, done.
REQ-025 Reset asserted during wait state of fetch -> avm_read=0 next cycle, instr=0, no done.
